// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the load/store controller and its load aligner.
//   MODE_*      : access-size codes. They are identical to the data memory's Mode pins and to
//                 the req_size encoding, so a store's size goes straight onto mem_mode.
//   lsu_state_e : controller FSM state encoding.
//   misaligned(): alignment / legality check applied when a request is accepted.
package mem_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10,
        StErr    = 2'b11
    } lsu_state_e;

    // Returns 1 when the request is illegal: a reserved size, or a halfword/word access
    // whose address is not naturally aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            MODE_BYTE: bad = 1'b0;
            MODE_HALF: bad = addr_lo[0];
            MODE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: purely combinational lane selection and extension of a loaded word.
//   word        in  32  full word returned by the memory (word-mode read)
//   addr_lo     in  2   byte offset of the load within the word
//   size        in  2   MODE_BYTE / MODE_HALF / MODE_WORD
//   is_unsigned in  1   zero-extend byte/half results instead of sign-extending
//   data        out 32  right-aligned, extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        ext_bit;

    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        // Halfword accesses are already known to be aligned, so only addr_lo[1] matters.
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data    = word;
        ext_bit = 1'b0;
        case (size)
            MODE_BYTE: begin
                ext_bit = ~is_unsigned & byte_lane[7];
                data    = {{24{ext_bit}}, byte_lane};
            end
            MODE_HALF: begin
                ext_bit = ~is_unsigned & half_lane[15];
                data    = {{16{ext_bit}}, half_lane};
            end
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the MEM pipeline stage and the data memory.
// Accepts one request at a time (valid/ready), rejects illegal/misaligned requests with a
// one-cycle error response, otherwise performs a single memory access followed by a
// one-cycle response carrying extended load data. busy stalls the pipeline meanwhile.
//   clk, clr_n             clock (rising edge) and asynchronous active-low reset
//   req_valid / req_ready  request handshake; ready only while idle
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid, rsp_err, rsp_rdata                         one-cycle response
//   busy                   high whenever a request is in flight
//   mem_addr, mem_wdata, mem_mode, mem_str, mem_sel, mem_ld, mem_rdata  memory pins
module lsu_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,

    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,

    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_mode,
    output logic                  mem_str,
    output logic                  mem_sel,
    output logic                  mem_ld,
    input  logic [31:0]           mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;

    logic                  accept;
    logic [31:0]           load_data;

    assign accept = (state_q == StIdle) && req_valid;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = misaligned(req_size, req_addr[1:0]) ? StErr : StAccess;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured only on the accepting edge and held until the next accept.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

    load_align u_load_align (
        .word        (mem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // Outputs decode directly from the state register, so an asynchronous reset drops the
    // strobe immediately and aborts a store still in ACCESS.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        mem_sel   = 1'b0;
        mem_str   = 1'b0;
        mem_mode  = MODE_WORD;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_ld    = 1'b1;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            StAccess: begin
                mem_sel  = 1'b1;
                mem_str  = we_q;
                // Loads always read the whole word; the lane is picked out afterwards.
                mem_mode = we_q ? size_q : MODE_WORD;
            end
            StResp: begin
                // Mode held from ACCESS so the memory keeps presenting the same word.
                mem_mode  = we_q ? size_q : MODE_WORD;
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? 32'h0 : load_data;
            end
            StErr: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_mode;
    logic        mem_str;
    logic        mem_sel;
    logic        mem_ld;
    logic [31:0] mem_rdata;

    int total;
    int bad;

    logic [7:0] ram     [0:4095];  // data memory attached to the DUT
    logic [7:0] ref_mem [0:4095];  // reference image, updated from request semantics

    lsu_mem_ctrl #(.ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_mode     (mem_mode),
        .mem_str      (mem_str),
        .mem_sel      (mem_sel),
        .mem_ld       (mem_ld),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte/half/word-mode RAM: synchronous write, read word registered on the edge.
    always @(posedge clk) begin
        if (mem_sel) begin
            if (mem_str) begin
                case (mem_mode)
                    2'b00: ram[mem_addr] <= mem_wdata[7:0];
                    2'b01: begin
                        ram[{mem_addr[11:1], 1'b0}] <= mem_wdata[7:0];
                        ram[{mem_addr[11:1], 1'b1}] <= mem_wdata[15:8];
                    end
                    default: begin
                        ram[{mem_addr[11:2], 2'b00}] <= mem_wdata[7:0];
                        ram[{mem_addr[11:2], 2'b01}] <= mem_wdata[15:8];
                        ram[{mem_addr[11:2], 2'b10}] <= mem_wdata[23:16];
                        ram[{mem_addr[11:2], 2'b11}] <= mem_wdata[31:24];
                    end
                endcase
            end else begin
                mem_rdata <= {ram[{mem_addr[11:2], 2'b11}], ram[{mem_addr[11:2], 2'b10}],
                              ram[{mem_addr[11:2], 2'b01}], ram[{mem_addr[11:2], 2'b00}]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input int size, input int addr);
        return (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int size, input bit uns, input int addr);
        int v;
        if (size == 0) begin
            v = ref_mem[addr];
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = ref_mem[addr] + 256 * ref_mem[addr + 1];
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = ref_mem[addr] + (ref_mem[addr + 1] << 8) + (ref_mem[addr + 2] << 16)
                + (ref_mem[addr + 3] << 24);
        end
        return v;
    endfunction

    task automatic model_store(input int size, input int addr, input logic [31:0] w);
        int n;
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[addr + i] = w[8*i +: 8];
    endtask

    // One complete request from an idle controller, checking every cycle of the exchange.
    task automatic do_req(input bit we, input int size, input bit uns, input int addr,
                          input logic [31:0] wdata);
        logic [31:0] exp;
        bit          err;
        err = model_err(size, addr);
        exp = (we || err) ? 32'h0 : model_load(size, uns, addr);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size[1:0];
        req_unsigned = uns;
        req_addr     = addr[11:0];
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        // Later changes to req_* must have no effect.
        req_valid    = 1'b0;
        req_we       = $urandom_range(0, 1) != 0;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1) != 0;
        req_addr     = 12'($urandom);
        req_wdata    = $urandom;
        if (err) begin
            chk("err_valid", {31'b0, rsp_valid}, 32'd1);
            chk("err_flag", {31'b0, rsp_err}, 32'd1);
            chk("err_rdata", rsp_rdata, 32'h0);
            chk("err_nosel", {31'b0, mem_sel}, 32'd0);
            chk("err_busy", {31'b0, busy}, 32'd1);
        end else begin
            chk("acc_busy", {31'b0, busy}, 32'd1);
            chk("acc_ready", {31'b0, req_ready}, 32'd0);
            chk("acc_novalid", {31'b0, rsp_valid}, 32'd0);
            chk("acc_sel", {31'b0, mem_sel}, 32'd1);
            chk("acc_str", {31'b0, mem_str}, {31'b0, we});
            chk("acc_addr", {20'b0, mem_addr}, addr);
            chk("acc_mode", {30'b0, mem_mode}, we ? size : 2);
            @(posedge clk);
            #1;
            if (we) model_store(size, addr, wdata);
            chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_err", {31'b0, rsp_err}, 32'd0);
            chk("rsp_rdata", rsp_rdata, exp);
            chk("rsp_busy", {31'b0, busy}, 32'd1);
            chk("rsp_nosel", {31'b0, mem_sel}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("end_novalid", {31'b0, rsp_valid}, 32'd0);
        chk("end_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          addr;
        int          size;
        bit          we;
        bit          uns;
        logic [31:0] exp_q [$];
        int          acc;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem_rdata    = 32'h0;
        clr_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 12'h0;
        req_wdata    = 32'h0;

        #2;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_sel", {31'b0, mem_sel}, 32'd0);
        chk("rst_str", {31'b0, mem_str}, 32'd0);
        chk("rst_mode", {30'b0, mem_mode}, 32'd2);
        chk("rst_addr", {20'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ld", {31'b0, mem_ld}, 32'd1);
        #10;
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store/load, byte and half extension.
        do_req(1'b1, 2, 1'b0, 12'h010, 32'hDEADBEEF);
        do_req(1'b0, 2, 1'b0, 12'h010, 32'h0);
        chk("lw_literal", model_load(2, 1'b0, 12'h010), 32'hDEADBEEF);
        do_req(1'b1, 0, 1'b0, 12'h013, 32'h00000080);
        do_req(1'b0, 0, 1'b0, 12'h013, 32'h0);
        do_req(1'b0, 0, 1'b1, 12'h013, 32'h0);
        do_req(1'b0, 1, 1'b0, 12'h012, 32'h0);
        do_req(1'b0, 1, 1'b1, 12'h010, 32'h0);
        do_req(1'b1, 1, 1'b0, 12'h022, 32'h00001234);
        do_req(1'b0, 2, 1'b0, 12'h020, 32'h0);
        do_req(1'b0, 0, 1'b0, 12'h021, 32'h0);

        // Illegal requests, then confirm memory untouched.
        do_req(1'b0, 2, 1'b0, 12'h011, 32'h0);
        do_req(1'b0, 1, 1'b0, 12'h013, 32'h0);
        do_req(1'b1, 3, 1'b0, 12'h000, 32'hFFFFFFFF);
        do_req(1'b1, 2, 1'b0, 12'h012, 32'h55555555);
        do_req(1'b0, 2, 1'b0, 12'h010, 32'h0);
        do_req(1'b0, 2, 1'b0, 12'h000, 32'h0);

        // Reset in the middle of a store's ACCESS cycle aborts it.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h010;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_str_before", {31'b0, mem_str}, 32'd1);
        clr_n = 1'b0;
        #1;
        chk("abort_str", {31'b0, mem_str}, 32'd0);
        chk("abort_sel", {31'b0, mem_sel}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_addr", {20'b0, mem_addr}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_novalid", {31'b0, rsp_valid}, 32'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_novalid2", {31'b0, rsp_valid}, 32'd0);
        do_req(1'b0, 2, 1'b0, 12'h010, 32'h0);

        // Back-to-back requests with req_valid held high.
        model_store(2, 12'h030, 32'h11223344);
        exp_q.push_back(32'h0);
        exp_q.push_back(model_load(2, 1'b0, 12'h030));
        exp_q.push_back(model_load(0, 1'b0, 12'h031));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h030;
        req_wdata = 32'h11223344;
        acc = 1;
        for (int n = 0; n < 9; n++) begin
            @(posedge clk);
            #1;
            chk("b2b_ready", {31'b0, req_ready}, {31'b0, (n % 3) == 2});
            chk("b2b_valid", {31'b0, rsp_valid}, {31'b0, (n % 3) == 1});
            if (rsp_valid && exp_q.size() > 0) chk("b2b_rdata", rsp_rdata, exp_q.pop_front());
            if (req_ready) begin
                if (acc == 1) begin
                    req_we   = 1'b0;
                    req_addr = 12'h030;
                end else begin
                    req_we   = 1'b0;
                    req_size = 2'b00;
                    req_addr = 12'h031;
                end
                if (acc == 3) req_valid = 1'b0;
                acc++;
            end
            if (n == 7) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_all_rsp", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;

        // Randomised mix over a small window, including illegal sizes and offsets.
        for (int k = 0; k < 60; k++) begin
            addr = 12'h100 + $urandom_range(0, 31);
            size = $urandom_range(0, 3);
            we   = $urandom_range(0, 1) != 0;
            uns  = $urandom_range(0, 1) != 0;
            do_req(we, size, uns, addr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
